// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority search starting past the last winner, registered one-hot grant.
// Optional tenure quantum with preemption is enabled by defining RR_ARB_QUANTUM_EN.
module rr_arbiter #(
    parameter int OUTW    = 3,
    parameter int QUANTUM = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [(1<<OUTW)-1:0] req,
    output logic [(1<<OUTW)-1:0] grant,
    output logic [OUTW-1:0]      grant_idx,
    output logic                 grant_valid,
    output logic                 preempt
);
    localparam int N = 1 << OUTW;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    // Returns {found, index}; scanning from the far end lets the first hit in rotation order win.
    function automatic logic [OUTW:0] pick(input logic [OUTW-1:0] p, input logic [N-1:0] m);
        logic [OUTW:0]   res;
        logic [OUTW-1:0] k;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = p + i[OUTW-1:0];
            if (m[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [OUTW-1:0] grant_idx_q, grant_idx_d;
    logic           grant_valid_q, grant_valid_d;
    logic [OUTW-1:0] ptr_q, ptr_d;

    logic [OUTW:0]   pick_all;
    logic            sw;
    logic [OUTW-1:0] sw_idx;
    logic [OUTW-1:0] cur;

`ifdef RR_ARB_QUANTUM_EN
    logic [15:0]     hold_cnt_q, hold_cnt_d;
    logic            preempt_q, preempt_d;
    logic [OUTW:0]   pick_oth;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        cur           = grant_idx_q;
        pick_all      = pick(ptr_q, req);
        sw            = 1'b0;
        sw_idx        = '0;
`ifdef RR_ARB_QUANTUM_EN
        hold_cnt_d    = hold_cnt_q;
        preempt_d     = 1'b0;
        pick_oth      = pick(ptr_q, req & ~(ONE << cur));
`endif
        case (state_q)
            IDLE: begin
                sw     = pick_all[OUTW];
                sw_idx = pick_all[OUTW-1:0];
            end
            GRANT: begin
                if (req[cur]) begin
`ifdef RR_ARB_QUANTUM_EN
                    if (hold_cnt_q == 16'(QUANTUM - 1)) begin
                        // Quantum expired: hand over only if someone else is waiting.
                        sw         = pick_oth[OUTW];
                        sw_idx     = pick_oth[OUTW-1:0];
                        preempt_d  = pick_oth[OUTW];
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
`endif
                end else if (pick_all[OUTW]) begin
                    sw     = 1'b1;
                    sw_idx = pick_all[OUTW-1:0];
                end else begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sw) begin
            state_d       = GRANT;
            grant_d       = ONE << sw_idx;
            grant_idx_d   = sw_idx;
            grant_valid_d = 1'b1;
            ptr_d         = sw_idx + OUTW'(1);
`ifdef RR_ARB_QUANTUM_EN
            hold_cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= '0;
`ifdef RR_ARB_QUANTUM_EN
            hold_cnt_q    <= '0;
            preempt_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
`ifdef RR_ARB_QUANTUM_EN
            hold_cnt_q    <= hold_cnt_d;
            preempt_q     <= preempt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
`ifdef RR_ARB_QUANTUM_EN
    assign preempt     = preempt_q;
`else
    assign preempt     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomized scoreboard bench for rr_arbiter; reference model tracks owner/pointer as plain integers.
// Quantum behaviour is modelled and exercised when RR_ARB_QUANTUM_EN is defined.
module tb_rr_arbiter;
    localparam int OUTW = 3;
    localparam int N    = 8;
    localparam int Q    = 4;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    rr_arbiter #(.OUTW(OUTW), .QUANTUM(Q)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .grant_idx(grant_idx), .grant_valid(grant_valid), .preempt(preempt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input int p, input logic [7:0] m);
        for (int o = 0; o < N; o++)
            if (m[(p + o) % N]) return (p + o) % N;
        return -1;
    endfunction

    // Advance the model by one clock edge and return the outputs expected after it.
    function automatic exp_t step(input logic [7:0] r, input logic rs);
        exp_t e;
        int   k;
        logic pre;
        logic [7:0] oth;
        pre = 1'b0;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            k = pick(m_ptr, r);
            if (k >= 0) begin m_owner = k; m_ptr = (k + 1) % N; m_cnt = 0; end
        end else if (r[m_owner]) begin
`ifdef RR_ARB_QUANTUM_EN
            if (m_cnt == Q - 1) begin
                oth = r;
                oth[m_owner] = 1'b0;
                k = pick(m_ptr, oth);
                m_cnt = 0;
                if (k >= 0) begin m_owner = k; m_ptr = (k + 1) % N; pre = 1'b1; end
            end else begin
                m_cnt++;
            end
`else
            oth = r;
`endif
        end else begin
            k = pick(m_ptr, r);
            if (k >= 0) begin m_owner = k; m_ptr = (k + 1) % N; m_cnt = 0; end
            else m_owner = -1;
        end
        e.grant = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        e.idx   = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        e.valid = (m_owner >= 0);
        e.pre   = pre;
        return e;
    endfunction

    task automatic drive(input logic [7:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        sb.push_back(step(r, rs));
    endtask

    // Monitor: every output cycle is compared against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (grant !== e.grant || grant_idx !== e.idx || grant_valid !== e.valid || preempt !== e.pre) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t: got grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
                             $time, grant, grant_idx, grant_valid, preempt, e.grant, e.idx, e.valid, e.pre);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        drive(8'h00, 1'b1);
        repeat (5) drive(8'h00, 1'b0);
        // Two requesters, release in turn, then idle.
        drive(8'h24, 1'b0);
        drive(8'h24, 1'b0);
        drive(8'h20, 1'b0);
        drive(8'h20, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        // Full contention with each owner releasing after one cycle: pure rotation.
        drive(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            r = 8'hFF;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            drive(r, 1'b0);
        end
        // Reset mid-tenure restarts the pointer at 0.
        drive(8'h00, 1'b1);
        drive(8'h08, 1'b0);
        drive(8'h08, 1'b0);
        drive(8'h08, 1'b1);
        drive(8'h09, 1'b0);
        drive(8'h09, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        // Long holds: with the quantum these alternate / never preempt a lone owner.
        repeat (20) drive(8'h03, 1'b0);
        drive(8'h00, 1'b0);
        repeat (22) drive(8'h01, 1'b0);
        drive(8'h00, 1'b0);
        // Random traffic; the current owner tends to keep requesting.
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 9) < 8) r[m_owner] = 1'b1;
            drive(r, ($urandom_range(0, 99) == 0));
        end
        drive(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
